// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 4-digit multiplexed 7-segment scanner.
// Anode selects are active-low: a 0 bit lights that digit.
package seg7_pkg;

    localparam int         NDIG   = 4;
    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef logic [1:0] dig_idx_t;

    function automatic logic [3:0] onehot_an(input dig_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_prescale.sv
// Slot timer for the digit scanner: counts PRESCALE cycles per slot and steps idx 0..3.
// slot_end marks the last cycle of a slot; in_blank is high while the counter is below BLANK_CYC.
module seg7_prescale
    import seg7_pkg::*;
#(
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       clr,
    output logic [1:0] idx,
    output logic       slot_end,
    output logic       in_blank
);

    localparam int CNT_W = $clog2(PRESCALE);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    dig_idx_t         idx_q, idx_d;

    always_comb begin
        slot_end = (cnt_q == CNT_W'(PRESCALE - 1));
        cnt_d    = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // A zero-length blank window would compare an unsigned count against 0.
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (cnt_q < CNT_W'(BLANK_CYC));
        end
    endgenerate

    assign idx = idx_q;

endmodule

// File: rtl/seg7_scan.sv
// 4-digit multiplexed 7-segment scanner with tear-free frame-boundary updates and per-slot blanking.
// Optional leading-zero blanking when SEG7_LZB_EN is defined; ports are identical either way.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] din,
    input  logic        load,
    output logic [3:0]  x,
    output logic [3:0]  an,
    output logic        frame_tick
);

    logic     [1:0] idx;
    logic           slot_end;
    logic           in_blank;
    logic           frame_bnd;
    logic           lead_zero;

    logic [15:0] display_q, display_d;
    logic [15:0] pending_q, pending_d;
    logic        pend_vld_q, pend_vld_d;
    logic [3:0]  x_q, x_d;
    logic [3:0]  an_q, an_d;
    logic        tick_q, tick_d;

    seg7_prescale #(
        .PRESCALE  (PRESCALE),
        .BLANK_CYC (BLANK_CYC)
    ) u_prescale (
        .clk      (clk),
        .clr      (clr),
        .idx      (idx),
        .slot_end (slot_end),
        .in_blank (in_blank)
    );

    assign frame_bnd = slot_end && (idx == 2'd3);

`ifdef SEG7_LZB_EN
    // Digit k is dark when it and every more-significant nibble are zero.
    always_comb begin
        lead_zero = 1'b0;
        case (idx)
            2'd1:    lead_zero = (display_q[15:4]  == 12'h000);
            2'd2:    lead_zero = (display_q[15:8]  == 8'h00);
            2'd3:    lead_zero = (display_q[15:12] == 4'h0);
            default: lead_zero = 1'b0;
        endcase
    end
`else
    assign lead_zero = 1'b0;
`endif

    always_comb begin
        display_d  = display_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        tick_d     = 1'b0;

        // A load landing on the boundary itself is newer than anything pending.
        if (frame_bnd) begin
            if (load) begin
                display_d  = din;
                pend_vld_d = 1'b0;
                tick_d     = 1'b1;
            end else if (pend_vld_q) begin
                display_d  = pending_q;
                pend_vld_d = 1'b0;
                tick_d     = 1'b1;
            end
        end else if (load) begin
            pending_d  = din;
            pend_vld_d = 1'b1;
        end

        x_d  = display_q[{idx, 2'b00} +: 4];
        an_d = (in_blank || lead_zero) ? AN_OFF : onehot_an(idx);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            display_q  <= '0;
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
            x_q        <= 4'h0;
            an_q       <= AN_OFF;
            tick_q     <= 1'b0;
        end else begin
            display_q  <= display_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            x_q        <= x_d;
            an_q       <= an_d;
            tick_q     <= tick_d;
        end
    end

    assign x          = x_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed scanner for the 4-digit common-anode 7-segment display.
- Takes a 16-bit hex value and each slot drives one nibble on x plus a one-hot active-low digit select on an.
- x and an feed the hex-to-segment decoder directly (x = digit code, an = anode pass-through).
- Latches new values tear-free (updates only at frame boundaries) and inserts an anti-ghosting blank interval at the start of every digit slot.

Parameters:
- PRESCALE, 50000: clock cycles per digit slot; legal range is 4 or more.
- BLANK_CYC, 16: cycles at slot start with all anodes off; legal range is 0 to PRESCALE-2.

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous active-high reset
- din  in  16  value to display; din[3:0] is the rightmost digit
- load  in  1  one-cycle strobe; captures din
- x  out  4  nibble of the currently selected digit, registered
- an  out  4  active-low digit select, registered; bit k = digit k, bit 0 rightmost
- frame_tick  out  1  one-cycle pulse when the display register is updated at a frame boundary

Behaviour:
- Everything is synchronous to clk. When clr=1 at a rising edge, the following are cleared:
  - slot counter = 0, digit index idx = 0
  - display reg = 0, pending reg = 0, pending_valid = 0
  - x = 4'h0, an = 4'b1111, frame_tick = 0
- Slot counter runs 0..PRESCALE-1 and wraps.
- At wrap (slot_end), idx advances 0→1→2→3→0.
- Frame boundary = slot_end while idx==3.
- Registered outputs (one-cycle latency from counter/idx):
  - x = display[4*idx+3 : 4*idx]
  - an = 4'b1111 while slot counter < BLANK_CYC; otherwise ~(4'b0001 << idx)
- Load handling:
  - load=1, not at a frame boundary → pending ← din, pending_valid ← 1. A later load overwrites pending; last value wins.
  - Frame boundary with pending_valid=1 → display ← pending, pending_valid ← 0, frame_tick=1 on the next cycle.
  - load=1 coincident with a frame boundary → display ← din directly (bypass pending), pending_valid ← 0, frame_tick=1.
  - Frame boundary with no pending value and no load → display unchanged, frame_tick=0.
- A new display value is first visible in digit 0's slot, never mid-frame.
- BLANK_CYC=0 means no blanking; an is active for the whole slot.
- clr asserted mid-slot or mid-frame aborts immediately.
  - Any pending value is discarded.
  - First cycle after release shows idx 0, blanked per BLANK_CYC.
- din is sampled only on load; changes without load have no effect.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- Defined:
  - Digit k (k=1..3) is blanked (an bit k held 1 for its whole slot) when display nibbles k..3 are all zero.
  - Digit 0 is always shown.
  - Examples: 16'h0000 shows "   0"; 16'h00A5 shows "  A5"; 16'h0105 shows " 105".
  - x still carries the nibble value.
- Undefined: all four digits are always lit after the blank interval. Ports are identical in both builds.

Decomposition:
- Shared package seg7_pkg:
  - NDIG = 4
  - AN_OFF = 4'b1111
  - digit-index type (2 bits)
  - function onehot_an(idx) returning the active-low select
- The hex-to-segment decoder keeps its own constants.
- One natural sub-module: seg7_prescale.
  - Slot counter plus idx, parameterised by PRESCALE.
  - Outputs: idx, slot_end, in_blank (counter < BLANK_CYC).
- seg7_scan holds the load/pending/display logic and the output registers.

Test Plan (PRESCALE=8, BLANK_CYC=2 unless stated):
- Reset/scan: clr held 3 cycles then released, no load → an=1111 during reset and for 2 cycles. Then an=1110, x=0 for 6 cycles, then slots 1101/1011/0111 with period 8 cycles each.
- Load/tear-free: load din=16'h1234 at idx=1 → x stays 0 until the frame boundary. frame_tick pulses once. Next frame x = 4,3,2,1 in slots 0..3.
- Coincident load: load din=16'hBEEF on the exact frame-boundary cycle → frame_tick=1 next cycle. Next frame x = F,E,E,B. pending_valid=0 afterwards.
- Multiple loads: load 16'h1111 then 16'h2222 within one frame → only 2222 is displayed. Exactly one frame_tick.
- Reset mid-operation: load 16'hABCD, assert clr before the boundary → display stays 0000, no frame_tick, scan restarts at idx 0.
- SEG7_LZB_EN, BLANK_CYC=0: display 16'h00A5 → an bits 3 and 2 stay 1 for their full slots. Digits 1 and 0 show A and 5. Display 16'h0000 → only digit 0 is lit.
